// File: rtl/lenet_wb_pkg.sv
// Shared definitions for the LeNet write-back path and its read-side peers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lenet_wb_pkg;

    // Write-back controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } wb_state_t;

    // Four channels share one 32-bit SRAM word, one byte each
    localparam int BYTES_PER_WORD = 4;

    // Bank geometry defaults, kept identical to the read-side address generators
    localparam int DEF_BANK_R = 3;
    localparam int DEF_BANK_C = 3;
    localparam int DEF_ADDR_W = 10;

    // Index width that stays at least one bit for degenerate sizes
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/wb_addr_gen.sv
// Counter nest turning the channel/row/column beat order into bank, byte lane and word address.
// Latency: outputs are combinational from the counters; counters advance on the cycle after step.
// Backpressure: none of its own; it moves only when the caller asserts step.
module wb_addr_gen
    import lenet_wb_pkg::*;
#(
    parameter int BANK_R = DEF_BANK_R,
    parameter int BANK_C = DEF_BANK_C,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DIM_W  = 6,
    parameter int N_BANK = BANK_R * BANK_C,
    parameter int BANK_W = clog2_min1(N_BANK),
    parameter int LANE_W = clog2_min1(BYTES_PER_WORD)
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              clear,
    input  logic              step,
    input  logic [DIM_W-1:0]  cfg_w,
    input  logic [DIM_W-1:0]  cfg_h,
    input  logic [DIM_W-1:0]  cfg_ch,
    input  logic [ADDR_W-1:0] cfg_wpr,
    input  logic [ADDR_W-1:0] cfg_wpp,
    output logic [BANK_W-1:0] bank,
    output logic [LANE_W-1:0] lane,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam int CSUB_W = clog2_min1(BANK_C);
    localparam int RSUB_W = clog2_min1(BANK_R);
    localparam logic [CSUB_W-1:0] CSUB_LAST = CSUB_W'(BANK_C - 1);
    localparam logic [RSUB_W-1:0] RSUB_LAST = RSUB_W'(BANK_R - 1);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(BYTES_PER_WORD - 1);

    // Pixel position
    logic [DIM_W-1:0]  r_col;
    logic [DIM_W-1:0]  r_row;
    logic [DIM_W-1:0]  r_ch;
    // Bank sub-indices: column within the interleave, row within it, and row*BANK_C kept as a running sum
    logic [CSUB_W-1:0] r_csub;
    logic [RSUB_W-1:0] r_rsub;
    logic [BANK_W-1:0] r_rbank;
    // Address terms: column word, row base (row/BANK_R * wpr), plane base (ch/4 * wpp)
    logic [ADDR_W-1:0] r_cword;
    logic [ADDR_W-1:0] r_rbase;
    logic [ADDR_W-1:0] r_pbase;
    logic [LANE_W-1:0] r_lane;

    logic w_col_last;
    logic w_row_last;
    logic w_ch_last;

    assign w_col_last = (r_col == (cfg_w  - DIM_W'(1)));
    assign w_row_last = (r_row == (cfg_h  - DIM_W'(1)));
    assign w_ch_last  = (r_ch  == (cfg_ch - DIM_W'(1)));

    assign bank = r_rbank + BANK_W'(r_csub);
    assign lane = r_lane;
    assign addr = r_pbase + r_rbase + r_cword;
    assign last = w_col_last && w_row_last && w_ch_last;

    // Advance column innermost, carrying into row and then channel; the last beat returns everything to zero
    always_ff @(posedge clk or posedge srst) begin
        if (srst || clear) begin
            r_col   <= '0;
            r_row   <= '0;
            r_ch    <= '0;
            r_csub  <= '0;
            r_rsub  <= '0;
            r_rbank <= '0;
            r_cword <= '0;
            r_rbase <= '0;
            r_pbase <= '0;
            r_lane  <= '0;
        end else if (step) begin
            if (!w_col_last) begin
                r_col <= r_col + DIM_W'(1);
                if (r_csub == CSUB_LAST) begin
                    r_csub  <= '0;
                    r_cword <= r_cword + ADDR_W'(1);
                end else begin
                    r_csub  <= r_csub + CSUB_W'(1);
                end
            end else begin
                r_col   <= '0;
                r_csub  <= '0;
                r_cword <= '0;
                if (!w_row_last) begin
                    r_row <= r_row + DIM_W'(1);
                    if (r_rsub == RSUB_LAST) begin
                        r_rsub  <= '0;
                        r_rbank <= '0;
                        r_rbase <= r_rbase + cfg_wpr;
                    end else begin
                        r_rsub  <= r_rsub + RSUB_W'(1);
                        r_rbank <= r_rbank + BANK_W'(BANK_C);
                    end
                end else begin
                    r_row   <= '0;
                    r_rsub  <= '0;
                    r_rbank <= '0;
                    r_rbase <= '0;
                    if (w_ch_last) begin
                        r_ch    <= '0;
                        r_lane  <= '0;
                        r_pbase <= '0;
                    end else begin
                        r_ch <= r_ch + DIM_W'(1);
                        if (r_lane == LANE_LAST) begin
                            r_lane  <= '0;
                            r_pbase <= r_pbase + cfg_wpp;
                        end else begin
                            r_lane  <= r_lane + LANE_W'(1);
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/lenet_wb_writer.sv
// Write-back engine scattering PE-array output pixels into a banked, byte-lane packed SRAM group.
// Latency: an accepted beat appears on the SRAM write port one cycle later; done follows the last write in the same cycle.
// Backpressure: in_ready is high for the whole RUN state, so one beat per cycle; in_valid gaps simply idle the port.
module lenet_wb_writer
    import lenet_wb_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N_SET  = 2,
    parameter int BANK_R = DEF_BANK_R,
    parameter int BANK_C = DEF_BANK_C,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DIM_W  = 6,
    parameter int N_BANK = BANK_R * BANK_C
) (
    input  logic                      clk,
    input  logic                      srst,
    input  logic                      start,
    input  logic [DIM_W-1:0]          cfg_w,
    input  logic [DIM_W-1:0]          cfg_h,
    input  logic [DIM_W-1:0]          cfg_ch,
    input  logic [ADDR_W-1:0]         cfg_wpr,
    input  logic [ADDR_W-1:0]         cfg_wpp,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_SET*DATA_W-1:0]   in_data,
    output logic [N_BANK-1:0]         sram_write_enable,
    output logic [BYTES_PER_WORD-1:0] sram_bytemask,
    output logic [ADDR_W-1:0]         sram_waddr,
    output logic [N_SET*DATA_W-1:0]   sram_wdata,
    output logic                      busy,
    output logic                      done,
    output logic                      mem_sel
);

    localparam int BANK_W = clog2_min1(N_BANK);
    localparam int LANE_W = clog2_min1(BYTES_PER_WORD);

    wb_state_t r_state;
    wb_state_t w_state_nxt;

    logic [DIM_W-1:0]  r_cfg_w;
    logic [DIM_W-1:0]  r_cfg_h;
    logic [DIM_W-1:0]  r_cfg_ch;
    logic [ADDR_W-1:0] r_cfg_wpr;
    logic [ADDR_W-1:0] r_cfg_wpp;

    logic [N_BANK-1:0]         r_we;
    logic [BYTES_PER_WORD-1:0] r_mask;
    logic [ADDR_W-1:0]         r_waddr;
    logic [N_SET*DATA_W-1:0]   r_wdata;
    logic                      r_mem_sel;

    logic                      w_start_go;
    logic                      w_cfg_zero;
    logic                      w_accept;
    logic [BANK_W-1:0]         w_bank;
    logic [LANE_W-1:0]         w_lane;
    logic [ADDR_W-1:0]         w_addr;
    logic                      w_last;
    logic [N_BANK-1:0]         w_we_nxt;
    logic [BYTES_PER_WORD-1:0] w_mask_nxt;

    assign w_start_go = start && (r_state == ST_IDLE);
    assign w_cfg_zero = (cfg_w == '0) || (cfg_h == '0) || (cfg_ch == '0);
    assign w_accept   = in_valid && (r_state == ST_RUN);

    wb_addr_gen #(
        .BANK_R (BANK_R),
        .BANK_C (BANK_C),
        .ADDR_W (ADDR_W),
        .DIM_W  (DIM_W),
        .N_BANK (N_BANK),
        .BANK_W (BANK_W),
        .LANE_W (LANE_W)
    ) u_addr_gen (
        .clk     (clk),
        .srst    (srst),
        .clear   (w_start_go),
        .step    (w_accept),
        .cfg_w   (r_cfg_w),
        .cfg_h   (r_cfg_h),
        .cfg_ch  (r_cfg_ch),
        .cfg_wpr (r_cfg_wpr),
        .cfg_wpp (r_cfg_wpp),
        .bank    (w_bank),
        .lane    (w_lane),
        .addr    (w_addr),
        .last    (w_last)
    );

    // State register
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: an empty map skips straight to FLUSH so it still completes with a done pulse
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = w_cfg_zero ? ST_FLUSH : ST_RUN;
                end
            end
            ST_RUN: begin
                if (in_valid && w_last) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Map geometry is captured once per start so the inputs may change during the map
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            r_cfg_w   <= '0;
            r_cfg_h   <= '0;
            r_cfg_ch  <= '0;
            r_cfg_wpr <= '0;
            r_cfg_wpp <= '0;
        end else if (w_start_go) begin
            r_cfg_w   <= cfg_w;
            r_cfg_h   <= cfg_h;
            r_cfg_ch  <= cfg_ch;
            r_cfg_wpr <= cfg_wpr;
            r_cfg_wpp <= cfg_wpp;
        end
    end

    // One-cold bank enable and byte mask for the beat being accepted; all ones otherwise
    always_comb begin
        w_we_nxt   = '1;
        w_mask_nxt = '1;
        if (w_accept) begin
            w_we_nxt[w_bank]   = 1'b0;
            w_mask_nxt[w_lane] = 1'b0;
        end
    end

    // Registered SRAM write port; address and data hold between writes
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            r_we    <= '1;
            r_mask  <= '1;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_we   <= w_we_nxt;
            r_mask <= w_mask_nxt;
            if (w_accept) begin
                r_waddr <= w_addr;
                r_wdata <= in_data;
            end
        end
    end

    // Ping-pong select flips at the end of the done cycle
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            r_mem_sel <= 1'b0;
        end else if (r_state == ST_FLUSH) begin
            r_mem_sel <= ~r_mem_sel;
        end
    end

    assign in_ready          = (r_state == ST_RUN);
    assign busy              = (r_state != ST_IDLE);
    assign done              = (r_state == ST_FLUSH);
    assign mem_sel           = r_mem_sel;
    assign sram_write_enable = r_we;
    assign sram_bytemask     = r_mask;
    assign sram_waddr        = r_waddr;
    assign sram_wdata        = r_wdata;

endmodule

// File: tb/tb_lenet_wb_writer.sv
// Self-checking bench for lenet_wb_writer: a scoreboard of expected SRAM writes drained by a monitor.
// Latency: expected writes are queued at beat acceptance and matched one cycle later.
// Backpressure: stimulus honours in_ready and optionally inserts random in_valid gaps.
module tb_lenet_wb_writer;

    localparam int DATA_W = 8;
    localparam int N_SET  = 2;
    localparam int BANK_R = 3;
    localparam int BANK_C = 3;
    localparam int N_BANK = 9;
    localparam int ADDR_W = 10;
    localparam int DIM_W  = 6;

    logic                    clk;
    logic                    srst;
    logic                    start;
    logic [DIM_W-1:0]        cfg_w, cfg_h, cfg_ch;
    logic [ADDR_W-1:0]       cfg_wpr, cfg_wpp;
    logic                    in_valid;
    logic                    in_ready;
    logic [N_SET*DATA_W-1:0] in_data;
    logic [N_BANK-1:0]       sram_write_enable;
    logic [3:0]              sram_bytemask;
    logic [ADDR_W-1:0]       sram_waddr;
    logic [N_SET*DATA_W-1:0] sram_wdata;
    logic                    busy, done, mem_sel;

    lenet_wb_writer #(
        .DATA_W (DATA_W),
        .N_SET  (N_SET),
        .BANK_R (BANK_R),
        .BANK_C (BANK_C),
        .ADDR_W (ADDR_W),
        .DIM_W  (DIM_W)
    ) dut (
        .clk               (clk),
        .srst              (srst),
        .start             (start),
        .cfg_w             (cfg_w),
        .cfg_h             (cfg_h),
        .cfg_ch            (cfg_ch),
        .cfg_wpr           (cfg_wpr),
        .cfg_wpp           (cfg_wpp),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .sram_write_enable (sram_write_enable),
        .sram_bytemask     (sram_bytemask),
        .sram_waddr        (sram_waddr),
        .sram_wdata        (sram_wdata),
        .busy              (busy),
        .done              (done),
        .mem_sel           (mem_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [N_BANK-1:0]       we;
        logic [3:0]              mask;
        logic [ADDR_W-1:0]       addr;
        logic [N_SET*DATA_W-1:0] data;
    } wr_t;

    wr_t sb[$];
    int  n_chk    = 0;
    int  n_fail   = 0;
    int  done_cnt = 0;
    int  log_n    = 0;
    logic                    exp_mem = 1'b0;
    logic [N_BANK-1:0]       log_we   [0:255];
    logic [3:0]              log_mask [0:255];
    logic [ADDR_W-1:0]       log_addr [0:255];
    logic [N_SET*DATA_W-1:0] log_data [0:255];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    // Reference placement using plain division and modulo
    function automatic wr_t model(input int ch, input int r, input int c,
                                  input int wpr, input int wpp, input logic [15:0] d);
        wr_t m;
        int  bank;
        int  a;
        bank = (r % BANK_R) * BANK_C + (c % BANK_C);
        a    = (ch / 4) * wpp + (r / BANK_R) * wpr + (c / BANK_C);
        m.we   = '1;
        m.we[bank] = 1'b0;
        m.mask = 4'hF;
        m.mask[ch % 4] = 1'b0;
        m.addr = a[ADDR_W-1:0];
        m.data = d;
        return m;
    endfunction

    function automatic logic [15:0] pix_data(input int idx);
        logic [7:0] hi;
        logic [7:0] lo;
        hi = 8'(idx * 7 + 3);
        lo = 8'hC3 ^ 8'(idx);
        return {hi, lo};
    endfunction

    // Monitor: every strobe must match the head of the scoreboard; idle cycles keep the mask all ones
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (!srst) begin
                if (done) done_cnt++;
                if (sram_write_enable != '1) begin
                    if (sb.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_strobe: got we=0x%0h addr=0x%0h, required no write",
                                 sram_write_enable, sram_waddr);
                    end else begin
                        e = sb.pop_front();
                        chk("wr_enable", 32'(sram_write_enable), 32'(e.we));
                        chk("wr_mask",   32'(sram_bytemask),     32'(e.mask));
                        chk("wr_addr",   32'(sram_waddr),        32'(e.addr));
                        chk("wr_data",   32'(sram_wdata),        32'(e.data));
                        if (log_n < 256) begin
                            log_we[log_n]   = sram_write_enable;
                            log_mask[log_n] = sram_bytemask;
                            log_addr[log_n] = sram_waddr;
                            log_data[log_n] = sram_wdata;
                        end
                        log_n++;
                    end
                end else begin
                    chk("idle_mask", 32'(sram_bytemask), 32'hF);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_we"},      32'(sram_write_enable), 32'h1FF);
        chk({tag, "_mask"},    32'(sram_bytemask),     32'hF);
        chk({tag, "_waddr"},   32'(sram_waddr),        32'h0);
        chk({tag, "_wdata"},   32'(sram_wdata),        32'h0);
        chk({tag, "_ready"},   32'(in_ready),          32'h0);
        chk({tag, "_busy"},    32'(busy),              32'h0);
        chk({tag, "_done"},    32'(done),              32'h0);
        chk({tag, "_mem_sel"}, 32'(mem_sel),           32'h0);
    endtask

    // Called at posedge+1; pulses start for one cycle
    task automatic do_start(input int w, input int h, input int nch, input int wpr, input int wpp);
        cfg_w   = DIM_W'(w);
        cfg_h   = DIM_W'(h);
        cfg_ch  = DIM_W'(nch);
        cfg_wpr = ADDR_W'(wpr);
        cfg_wpp = ADDR_W'(wpp);
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
    endtask

    // Issues beats in channel/row/column order, queueing each accepted one
    task automatic run_beats(input int w, input int h, input int nch, input int wpr, input int wpp,
                             input bit gaps, input int stop_after, input int poke_at);
        int  ch = 0, r = 0, c = 0;
        int  accepted = 0;
        int  total;
        int  budget;
        bit  acc;
        total  = w * h * nch;
        budget = 8 * total + 50;
        while (accepted < total && accepted < stop_after && budget > 0) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = pix_data(accepted);
            if (accepted == poke_at) begin
                cfg_ch = '0;
                start  = 1'b1;
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            start = 1'b0;
            budget--;
            if (acc) begin
                sb.push_back(model(ch, r, c, wpr, wpp, pix_data(accepted)));
                accepted++;
                if (c == w - 1) begin
                    c = 0;
                    if (r == h - 1) begin
                        r = 0;
                        ch++;
                    end else begin
                        r++;
                    end
                end else begin
                    c++;
                end
            end
        end
        in_valid = 1'b0;
        if (accepted < total && accepted < stop_after) begin
            n_chk++;
            n_fail++;
            $display("FAIL beat_budget: accepted %0d beats, required %0d", accepted, total);
        end
    endtask

    // Called in the cycle where done is expected
    task automatic finish_map(input int done_before, input bit poke_done);
        chk("done_pulse", 32'(done), 32'h1);
        chk("busy_at_done", 32'(busy), 32'h1);
        if (poke_done) begin
            cfg_ch = '0;
            start  = 1'b1;
        end
        exp_mem = ~exp_mem;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("done_after", 32'(done), 32'h0);
        chk("busy_after", 32'(busy), 32'h0);
        chk("ready_after", 32'(in_ready), 32'h0);
        chk("mem_sel", 32'(mem_sel), 32'(exp_mem));
        chk("sb_drained", 32'(sb.size()), 32'h0);
        chk("done_count", 32'(done_cnt), 32'(done_before + 1));
    endtask

    task automatic map(input int w, input int h, input int nch, input int wpr, input int wpp,
                       input bit gaps, input int poke_at, input bit poke_done);
        int d0;
        d0    = done_cnt;
        log_n = 0;
        do_start(w, h, nch, wpr, wpp);
        chk("ready_in_run", 32'(in_ready), 32'h1);
        run_beats(w, h, nch, wpr, wpp, gaps, 1 << 20, poke_at);
        finish_map(d0, poke_done);
    endtask

    initial begin
        int d0;
        srst     = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        cfg_w    = '0;
        cfg_h    = '0;
        cfg_ch   = '0;
        cfg_wpr  = '0;
        cfg_wpp  = '0;
        #12;
        check_reset_vals("reset");
        #10;
        srst = 1'b0;
        @(posedge clk);
        #1;

        // 4x4, one channel
        map(4, 4, 1, 2, 4, 1'b0, -1, 1'b0);
        chk("t1_count",   32'(log_n),        32'd16);
        chk("t1_p00_we",  32'(log_we[0]),    32'h1FE);
        chk("t1_p00_msk", 32'(log_mask[0]),  32'hE);
        chk("t1_p00_adr", 32'(log_addr[0]),  32'h0);
        chk("t1_p33_we",  32'(log_we[15]),   32'h1FE);
        chk("t1_p33_adr", 32'(log_addr[15]), 32'h3);
        chk("t1_p21_we",  32'(log_we[9]),    32'h17F);
        chk("t1_p21_adr", 32'(log_addr[9]),  32'h0);

        // Same geometry, six channels: second plane starts at wpp
        map(4, 4, 6, 2, 4, 1'b0, -1, 1'b0);
        chk("t2_count",     32'(log_n),              32'd96);
        chk("t2_c4_adr",    32'(log_addr[64]),       32'h4);
        chk("t2_c4_msk",    32'(log_mask[64]),       32'hE);
        chk("t2_c5_we",     32'(log_we[86]),         32'h1DF);
        chk("t2_c5_msk",    32'(log_mask[86]),       32'hD);
        chk("t2_c5_adr",    32'(log_addr[86]),       32'h4);
        chk("t2_c5_set0",   32'(log_data[86][7:0]),  32'h95);
        chk("t2_c5_set1",   32'(log_data[86][15:8]), 32'h5D);

        // Random in_valid gaps: same write sequence expected
        map(4, 4, 6, 2, 4, 1'b1, -1, 1'b0);
        chk("t3_count", 32'(log_n), 32'd96);

        // Reset after seven beats, with mem_sel currently 1
        chk("t5_mem_pre", 32'(mem_sel), 32'h1);
        log_n = 0;
        do_start(4, 4, 1, 2, 4);
        run_beats(4, 4, 1, 2, 4, 1'b0, 7, -1);
        @(negedge clk);
        #2;
        d0   = done_cnt;
        srst = 1'b1;
        #1;
        check_reset_vals("abort");
        exp_mem = 1'b0;
        sb.delete();
        chk("t5_written", 32'(log_n), 32'd7);
        @(negedge clk);
        #2;
        srst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t5_no_done", 32'(done_cnt), 32'(d0));
        chk("t5_idle", 32'(busy), 32'h0);
        map(4, 4, 1, 2, 4, 1'b0, -1, 1'b0);
        chk("t5_count",  32'(log_n),       32'd16);
        chk("t5_first",  32'(log_addr[0]), 32'h0);
        chk("t5_firstb", 32'(log_we[0]),   32'h1FE);

        // Empty map: done next cycle, no strobes
        d0    = done_cnt;
        log_n = 0;
        do_start(4, 4, 0, 2, 4);
        chk("t4_ready", 32'(in_ready), 32'h0);
        finish_map(d0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("t4_no_write", 32'(log_n), 32'h0);

        // Back-to-back maps with start pokes while busy and during done
        map(4, 4, 1, 2, 4, 1'b0, 5, 1'b1);
        chk("t6_first_mem", 32'(mem_sel), 32'h1);
        map(5, 4, 2, 2, 6, 1'b0, 11, 1'b0);
        chk("t6_second_mem", 32'(mem_sel), 32'h0);
        chk("t6_count", 32'(log_n), 32'd40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
